// File: rtl/delay_pkg.sv
// Shared types and constants for the delay-line controller: FSM state encoding,
// gain format and saturation bounds derived from a sample width.
package delay_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_READ,
        ST_MIX,
        ST_WRITE
    } state_t;

    localparam int GAIN_W    = 8;
    localparam int GAIN_FRAC = 7;

    function automatic longint sat_max(input int width);
        return (longint'(1) <<< (width - 1)) - longint'(1);
    endfunction

    function automatic longint sat_min(input int width);
        return -(longint'(1) <<< (width - 1));
    endfunction

endpackage

// File: rtl/delay_line_ctrl_if.sv
// Sample-side and memory-side bundles of the delay-line controller.
// Handshake: a sample transfers on a rising clock edge where in_valid && in_ready; out_valid is a one-cycle strobe with no back-pressure.
interface delay_sample_if #(
    parameter int DATA_WIDTH = 31,
    parameter int ADDR_WIDTH = 14
);
    logic                            in_valid;
    logic                            in_ready;
    logic [DATA_WIDTH-1:0]           in_data;
    logic [ADDR_WIDTH-1:0]           delay;
    logic [delay_pkg::GAIN_W-1:0]    gain;
    logic                            out_valid;
    logic [DATA_WIDTH-1:0]           out_data;

    modport master (output in_valid, in_data, delay, gain, input in_ready, out_valid, out_data);
    modport slave  (input in_valid, in_data, delay, gain, output in_ready, out_valid, out_data);
endinterface

interface delay_mem_if #(
    parameter int DATA_WIDTH = 31,
    parameter int ADDR_WIDTH = 14
);
    logic                  we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (output we, waddr, raddr, wdata, input rdata);
    modport slave  (input we, waddr, raddr, wdata, output rdata);
endinterface

// File: rtl/delay_sat_mix.sv
// Wet/dry mixer: scales the delayed sample by an unsigned Q1.7 gain, adds the
// dry sample and saturates to the signed sample range.
module delay_sat_mix
    import delay_pkg::*;
#(
    parameter int DATA_WIDTH = 31
) (
    input  logic signed [DATA_WIDTH-1:0] dry,
    input  logic signed [DATA_WIDTH-1:0] wet,
    input  logic        [GAIN_W-1:0]     gain,
    output logic signed [DATA_WIDTH-1:0] mixed
);
    localparam int PW = DATA_WIDTH + GAIN_W + 1;
    localparam logic signed [PW-1:0] MAX_W = PW'(sat_max(DATA_WIDTH));
    localparam logic signed [PW-1:0] MIN_W = PW'(sat_min(DATA_WIDTH));

    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] scaled;
    logic signed [PW-1:0] sum;

    // PW bits hold the full product and the post-shift sum without overflow.
    assign prod   = PW'(wet) * PW'($signed({1'b0, gain}));
    assign scaled = prod >>> GAIN_FRAC;
    assign sum    = scaled + PW'(dry);

    always_comb begin
        mixed = sum[DATA_WIDTH-1:0];
        if (sum > MAX_W) begin
            mixed = MAX_W[DATA_WIDTH-1:0];
        end else if (sum < MIN_W) begin
            mixed = MIN_W[DATA_WIDTH-1:0];
        end
    end
endmodule

// File: rtl/delay_line_ctrl.sv
// Circular-buffer delay-line controller: clears the memory, then for each sample reads the
// delayed tap, mixes it in and writes the new sample. Define DELAY_FEEDBACK_EN to store the mix instead.
module delay_line_ctrl
    import delay_pkg::*;
#(
    parameter int DATA_WIDTH   = 31,
    parameter int ADDR_WIDTH   = 14,
    parameter int SIZE         = 20000,
    parameter int READ_LATENCY = 2
) (
    input  logic          CLK,
    input  logic          RST,
    delay_sample_if.slave smp,
    delay_mem_if.master   mem,
    output state_t        state
);
    localparam int CW = ADDR_WIDTH + 1;
    localparam int LW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [CW-1:0]         SIZE_C   = CW'(SIZE);
    localparam logic [ADDR_WIDTH-1:0] D_MAX    = ADDR_WIDTH'(SIZE - 1);
    localparam logic [LW-1:0]         LAT_LAST = LW'(READ_LATENCY - 1);

    state_t                         state_nxt;
    logic [CW-1:0]                  init_cnt, init_cnt_nxt;
    logic [ADDR_WIDTH-1:0]          wptr, wptr_nxt;
    logic [LW-1:0]                  lat_cnt, lat_cnt_nxt;
    logic signed [DATA_WIDTH-1:0]   dry_q, dry_nxt;
    logic [GAIN_W-1:0]              gain_q, gain_nxt;
    logic [ADDR_WIDTH-1:0]          dly_q, dly_nxt;
    logic [ADDR_WIDTH-1:0]          raddr, raddr_nxt;
    logic [ADDR_WIDTH-1:0]          waddr, waddr_nxt;
    logic [DATA_WIDTH-1:0]          wdata, wdata_nxt;
    logic                           we, we_nxt;
    logic                           out_valid, out_valid_nxt;
    logic [DATA_WIDTH-1:0]          out_data, out_data_nxt;
    logic                           in_ready, in_ready_nxt;
    logic [ADDR_WIDTH-1:0]          eff_delay;
    logic signed [DATA_WIDTH-1:0]   mixed;
    logic [DATA_WIDTH-1:0]          fb_data;

    function automatic logic [ADDR_WIDTH-1:0] rd_addr(input logic [ADDR_WIDTH-1:0] w,
                                                      input logic [ADDR_WIDTH-1:0] d);
        logic [CW-1:0] a;
        if (w >= d) a = {1'b0, w} - {1'b0, d};
        else        a = {1'b0, w} + SIZE_C - {1'b0, d};
        return a[ADDR_WIDTH-1:0];
    endfunction

    // A delay of zero would read the slot being written, so it is pushed to one.
    always_comb begin
        eff_delay = smp.delay;
        if (smp.delay == '0) begin
            eff_delay = ADDR_WIDTH'(1);
        end else if ({1'b0, smp.delay} >= SIZE_C) begin
            eff_delay = D_MAX;
        end
    end

    delay_sat_mix #(.DATA_WIDTH(DATA_WIDTH)) u_mix (
        .dry   (dry_q),
        .wet   (mem.rdata),
        .gain  (gain_q),
        .mixed (mixed)
    );

`ifdef DELAY_FEEDBACK_EN
    assign fb_data = mixed;
`else
    assign fb_data = dry_q;
`endif

    always_comb begin
        state_nxt     = state;
        init_cnt_nxt  = init_cnt;
        wptr_nxt      = wptr;
        lat_cnt_nxt   = lat_cnt;
        dry_nxt       = dry_q;
        gain_nxt      = gain_q;
        dly_nxt       = dly_q;
        raddr_nxt     = raddr;
        waddr_nxt     = waddr;
        wdata_nxt     = wdata;
        out_data_nxt  = out_data;
        in_ready_nxt  = in_ready;
        we_nxt        = 1'b0;
        out_valid_nxt = 1'b0;
        case (state)
            ST_INIT: begin
                if (init_cnt == SIZE_C) begin
                    state_nxt    = ST_IDLE;
                    in_ready_nxt = 1'b1;
                    wptr_nxt     = '0;
                end else begin
                    we_nxt       = 1'b1;
                    waddr_nxt    = init_cnt[ADDR_WIDTH-1:0];
                    wdata_nxt    = '0;
                    init_cnt_nxt = init_cnt + CW'(1);
                end
            end
            ST_IDLE: begin
                if (smp.in_valid) begin
                    dry_nxt      = smp.in_data;
                    gain_nxt     = smp.gain;
                    dly_nxt      = eff_delay;
                    raddr_nxt    = rd_addr(wptr, eff_delay);
                    lat_cnt_nxt  = '0;
                    in_ready_nxt = 1'b0;
                    state_nxt    = ST_READ;
                end
            end
            ST_READ: begin
                raddr_nxt = rd_addr(wptr, dly_q);
                if (lat_cnt == LAT_LAST) state_nxt = ST_MIX;
                else                     lat_cnt_nxt = lat_cnt + LW'(1);
            end
            ST_MIX: begin
                out_data_nxt  = mixed;
                we_nxt        = 1'b1;
                waddr_nxt     = wptr;
                wdata_nxt     = fb_data;
                out_valid_nxt = 1'b1;
                state_nxt     = ST_WRITE;
            end
            ST_WRITE: begin
                wptr_nxt     = ({1'b0, wptr} == SIZE_C - CW'(1)) ? '0 : wptr + ADDR_WIDTH'(1);
                in_ready_nxt = 1'b1;
                state_nxt    = ST_IDLE;
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= ST_INIT;
            init_cnt  <= '0;
            wptr      <= '0;
            lat_cnt   <= '0;
            dry_q     <= '0;
            gain_q    <= '0;
            dly_q     <= '0;
            raddr     <= '0;
            waddr     <= '0;
            wdata     <= '0;
            we        <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            in_ready  <= 1'b0;
        end else begin
            state     <= state_nxt;
            init_cnt  <= init_cnt_nxt;
            wptr      <= wptr_nxt;
            lat_cnt   <= lat_cnt_nxt;
            dry_q     <= dry_nxt;
            gain_q    <= gain_nxt;
            dly_q     <= dly_nxt;
            raddr     <= raddr_nxt;
            waddr     <= waddr_nxt;
            wdata     <= wdata_nxt;
            we        <= we_nxt;
            out_valid <= out_valid_nxt;
            out_data  <= out_data_nxt;
            in_ready  <= in_ready_nxt;
        end
    end

    assign smp.in_ready  = in_ready;
    assign smp.out_valid = out_valid;
    assign smp.out_data  = out_data;
    assign mem.we        = we;
    assign mem.waddr     = waddr;
    assign mem.raddr     = raddr;
    assign mem.wdata     = wdata;
endmodule

// File: tb/tb_delay_line_ctrl.sv
// Self-checking bench for delay_line_ctrl with a 16-entry behavioural RAM (2-cycle read).
// Honours DELAY_FEEDBACK_EN when the build defines it.
module tb_delay_line_ctrl;
    import delay_pkg::*;

    localparam int DW = 31;
    localparam int AW = 14;
    localparam int SZ = 16;
    localparam int RL = 2;
    localparam longint MAXV = (longint'(1) <<< (DW - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (DW - 1));

    typedef struct {
        longint dry;
        int     dly;
        int     gain;
        longint exp;
    } vec_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    state_t dut_state;

    always #5 clk = ~clk;

    delay_sample_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) s ();
    delay_mem_if    #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) m ();

    delay_line_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SIZE(SZ), .READ_LATENCY(RL)
    ) dut (
        .CLK   (clk),
        .RST   (rst),
        .smp   (s),
        .mem   (m),
        .state (dut_state)
    );

    // Behavioural dual-port RAM: RAM register plus output register.
    logic [DW-1:0] ram [SZ];
    logic [DW-1:0] ram_q;
    always @(posedge clk) begin
        if (m.we) ram[m.waddr[3:0]] <= m.wdata;
        ram_q   <= ram[m.raddr[3:0]];
        m.rdata <= ram_q;
    end

    int tests = 0;
    int fails = 0;
    int out_cnt = 0;
    logic [DW-1:0] exp_q[$];
    longint m_mem[SZ];
    int     m_wptr;
    vec_t   tab[10];

    always @(negedge clk) if (s.out_valid) out_cnt++;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint got, input longint exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic longint floor_div128(input longint p);
        longint q;
        q = p / 128;
        if ((p % 128) != 0 && p < 0) q = q - 1;
        return q;
    endfunction

    function automatic longint model_mix(input longint dry, input longint wet, input int gain);
        longint r;
        r = dry + floor_div128(wet * gain);
        if (r > MAXV) r = MAXV;
        if (r < MINV) r = MINV;
        return r;
    endfunction

    function automatic int eff_d(input int dly);
        if (dly == 0) return 1;
        if (dly >= SZ) return SZ - 1;
        return dly;
    endfunction

    task automatic model_reset();
        m_wptr = 0;
        foreach (m_mem[i]) m_mem[i] = 0;
        exp_q.delete();
    endtask

    task automatic send(input longint dry, input int dly, input int gain,
                        output longint got, output int raddr_seen);
        int k;
        int ra;
        longint exp_out;
        longint exp_wdata;
        logic [DW-1:0] e;
        got = 0;
        raddr_seen = -1;
        k = 0;
        while (!s.in_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!s.in_ready) begin
            check("in_ready_timeout", 0, 1);
            return;
        end
        ra = (m_wptr - eff_d(dly) + SZ) % SZ;
        exp_out = model_mix(dry, m_mem[ra], gain);
`ifdef DELAY_FEEDBACK_EN
        exp_wdata = exp_out;
`else
        exp_wdata = dry;
`endif
        exp_q.push_back(exp_out[DW-1:0]);
        s.in_valid = 1'b1;
        s.in_data  = dry[DW-1:0];
        s.delay    = AW'(dly);
        s.gain     = 8'(gain);
        @(negedge clk);
        s.in_valid = 1'b0;
        raddr_seen = int'(m.raddr);
        check("raddr", longint'(m.raddr), longint'(ra));
        k = 1;
        while (!s.out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("latency", k, RL + 2);
        e = exp_q.pop_front();
        if (s.out_valid) begin
            got = longint'($signed(s.out_data));
            check("out_data", got, longint'($signed(e)));
            check("mem_we", longint'(m.we), 1);
            check("mem_waddr", longint'(m.waddr), longint'(m_wptr));
            check("mem_wdata", longint'($signed(m.wdata)), exp_wdata);
            m_mem[m_wptr] = exp_wdata;
            m_wptr = (m_wptr + 1) % SZ;
        end
    endtask

    task automatic check_init();
        int n;
        int writes;
        int ready_at;
        int oc;
        n = 0;
        writes = 0;
        ready_at = 0;
        oc = out_cnt;
        while (ready_at == 0 && n < 40) begin
            @(negedge clk);
            n++;
            if (s.in_ready) begin
                ready_at = n;
            end else if (m.we) begin
                check("init_waddr", longint'(m.waddr), longint'(writes));
                check("init_wdata", longint'(m.wdata), 0);
                writes++;
            end
        end
        check("init_writes", writes, SZ);
        check("init_ready_cycle", ready_at, SZ + 1);
        check("idle_we", longint'(m.we), 0);
        check("init_no_out", out_cnt, oc);
    endtask

    initial begin
        longint got;
        int     ra;
        int     guard;
        int     oc;
        logic [DW-1:0] rnd;

        s.in_valid = 1'b0;
        s.in_data  = '0;
        s.delay    = '0;
        s.gain     = '0;

        tab[0] = '{1000, 3, 128, 1000};
        tab[1] = '{0,    3, 128, 0};
        tab[2] = '{0,    3, 128, 0};
        tab[3] = '{0,    3, 128, 1000};
        tab[4] = '{0,    3, 128, 0};
        tab[5] = '{1024, 2, 64,  1024};
        tab[6] = '{0,    2, 64,  0};
        tab[7] = '{0,    2, 64,  512};
        tab[8] = '{0,    2, 64,  0};
`ifdef DELAY_FEEDBACK_EN
        tab[9] = '{0,    2, 64,  256};
`else
        tab[9] = '{0,    2, 64,  0};
`endif

        model_reset();
        repeat (3) @(negedge clk);
        check("rst_state", longint'(dut_state), longint'(ST_INIT));
        check("rst_we", longint'(m.we), 0);
        check("rst_in_ready", longint'(s.in_ready), 0);
        check("rst_out_valid", longint'(s.out_valid), 0);
        check("rst_out_data", longint'(s.out_data), 0);
        check("rst_waddr", longint'(m.waddr), 0);
        check("rst_raddr", longint'(m.raddr), 0);
        check("rst_wdata", longint'(m.wdata), 0);
        rst = 1'b0;
        check_init();

        for (int i = 0; i < 5; i++) begin
            send(tab[i].dry, tab[i].dly, tab[i].gain, got, ra);
            check("tab_impulse", got, tab[i].exp);
        end

        send(777, 1, 0, got, ra);
        send(0, 0, 128, got, ra);
        check("delay0_as_1", got, 777);

        send(555, 1, 0, got, ra);
        for (int i = 0; i < SZ - 2; i++) send(0, 1, 0, got, ra);
        send(0, 40, 128, got, ra);
        check("delay40_as_15", got, 555);

        send(MAXV, 1, 0, got, ra);
        send(MAXV, 1, 128, got, ra);
        check("sat_max", got, MAXV);
        send(MINV, 1, 0, got, ra);
        send(MINV, 1, 128, got, ra);
        check("sat_min", got, MINV);

        guard = 0;
        while (m_wptr != 14 && guard < 20) begin
            send(0, 1, 0, got, ra);
            guard++;
        end
        send(123, 5, 100, got, ra);
        check("raddr_w14_d5", ra, 9);
        send(0, 1, 0, got, ra);
        send(0, 1, 0, got, ra);
        send(0, 5, 100, got, ra);
        check("raddr_w1_d5", ra, 12);

        for (int i = 0; i < 48; i++) begin
            longint dry;
            case ($urandom_range(0, 2))
                0: dry = longint'($urandom_range(0, 4000)) - 2000;
                1: begin
                    rnd = DW'($urandom());
                    dry = longint'($signed(rnd));
                end
                default: dry = ($urandom_range(0, 1) != 0) ? MAXV - longint'($urandom_range(0, 100))
                                                           : MINV + longint'($urandom_range(0, 100));
            endcase
            send(dry, int'($urandom_range(0, 40)), int'($urandom_range(0, 255)), got, ra);
        end

        guard = 0;
        while (!s.in_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        s.in_valid = 1'b1;
        s.in_data  = DW'(4321);
        s.delay    = AW'(1);
        s.gain     = 8'(128);
        @(negedge clk);
        s.in_valid = 1'b0;
        check("state_read_before_rst", longint'(dut_state), longint'(ST_READ));
        oc = out_cnt;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mid_we", longint'(m.we), 0);
        check("rst_mid_state", longint'(dut_state), longint'(ST_INIT));
        rst = 1'b0;
        model_reset();
        check_init();
        check("no_out_after_rst", out_cnt, oc);

        for (int i = 5; i < 10; i++) begin
            send(tab[i].dry, tab[i].dly, tab[i].gain, got, ra);
            check("tab_echo", got, tab[i].exp);
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
